// File: rtl/rv32_lsu_pkg.sv
// Shared definitions for the RV32I load/store unit: widths, funct3 codes,
// FSM state encoding and a funct3 legality helper.
package rv32_lsu_pkg;

  localparam int DEF_ADDR_W = 12;
  localparam int DEF_DATA_W = 32;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  typedef enum logic [2:0] {
    ST_IDLE  = 3'd0,
    ST_LOAD  = 3'd1,
    ST_MERGE = 3'd2,
    ST_STORE = 3'd3,
    ST_RESP  = 3'd4
  } state_t;

  // Loads accept the signed and unsigned widths; stores only B/H/W.
  function automatic logic f3_legal(input logic [2:0] f3, input logic is_store);
    logic ok;
    case (f3)
      F3_B, F3_H, F3_W: ok = 1'b1;
      F3_BU, F3_HU:     ok = !is_store;
      default:          ok = 1'b0;
    endcase
    return ok;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Combinational lane logic: little-endian load extraction with sign/zero
// extension, read-modify-write store merge, and alignment check.
module lsu_align
  import rv32_lsu_pkg::*;
(
  input  logic [DEF_DATA_W-1:0] i_word,
  input  logic [1:0]            i_addr_lo,
  input  logic [2:0]            i_funct3,
  input  logic [DEF_DATA_W-1:0] i_wdata,
  output logic [DEF_DATA_W-1:0] o_load,
  output logic [DEF_DATA_W-1:0] o_merged,
  output logic                  o_misalign
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  // Select the addressed byte and halfword lanes of the read word.
  always_comb begin
    w_byte = 8'd0;
    case (i_addr_lo)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      2'd3:    w_byte = i_word[31:24];
      default: w_byte = 8'd0;
    endcase
    if (i_addr_lo[1]) begin
      w_half = i_word[31:16];
    end else begin
      w_half = i_word[15:0];
    end
  end

  // Extend the selected lane to a full word according to funct3.
  always_comb begin
    o_load = 32'd0;
    case (i_funct3)
      F3_B:    o_load = {{24{w_byte[7]}}, w_byte};
      F3_BU:   o_load = {24'd0, w_byte};
      F3_H:    o_load = {{16{w_half[15]}}, w_half};
      F3_HU:   o_load = {16'd0, w_half};
      F3_W:    o_load = i_word;
      default: o_load = 32'd0;
    endcase
  end

  // Replace the target lane of the read word with the store data.
  always_comb begin
    o_merged = i_word;
    case (i_funct3)
      F3_B: begin
        case (i_addr_lo)
          2'd0:    o_merged[7:0]   = i_wdata[7:0];
          2'd1:    o_merged[15:8]  = i_wdata[7:0];
          2'd2:    o_merged[23:16] = i_wdata[7:0];
          2'd3:    o_merged[31:24] = i_wdata[7:0];
          default: o_merged        = i_word;
        endcase
      end
      F3_H: begin
        if (i_addr_lo[1]) begin
          o_merged[31:16] = i_wdata[15:0];
        end else begin
          o_merged[15:0] = i_wdata[15:0];
        end
      end
      default: o_merged = i_wdata;
    endcase
  end

  // Halfwords need an even address, words a 4-byte aligned one.
  always_comb begin
    o_misalign = 1'b0;
    case (i_funct3)
      F3_H, F3_HU: o_misalign = i_addr_lo[0];
      F3_W:        o_misalign = |i_addr_lo;
      default:     o_misalign = 1'b0;
    endcase
  end

endmodule

// File: rtl/lsu_ctrl.sv
// RV32I load/store controller in front of a word-wide data RAM. Sub-word
// stores use a read-modify-write; every memory-side output is registered.
module lsu_ctrl
  import rv32_lsu_pkg::*;
#(
  parameter int ADDR_W = DEF_ADDR_W,
  parameter int DATA_W = DEF_DATA_W
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              i_req_valid,
  output logic              o_req_ready,
  input  logic              i_req_ld,
  input  logic              i_req_sw,
  input  logic [2:0]        i_funct3,
  input  logic [ADDR_W-1:0] i_addr,
  input  logic [DATA_W-1:0] i_wdata,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  output logic              o_mem_ld,
  output logic              o_mem_sw,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_resp_valid,
  output logic [DATA_W-1:0] o_rdata,
  output logic              o_err
);

  state_t            r_state;
  logic [1:0]        r_addr_lo;
  logic [2:0]        r_funct3;
  logic [DATA_W-1:0] r_wdata;
  logic              r_req_ready;
  logic [ADDR_W-1:0] r_mem_addr;
  logic [DATA_W-1:0] r_mem_wdata;
  logic              r_mem_ld;
  logic              r_mem_sw;
  logic              r_resp_valid;
  logic [DATA_W-1:0] r_rdata;
  logic              r_err;

  logic [1:0]        w_lane;
  logic [2:0]        w_f3;
  logic [DATA_W-1:0] w_load;
  logic [DATA_W-1:0] w_merged;
  logic              w_misalign;
  logic              w_accept;
  logic              w_err;
  logic [ADDR_W-1:0] w_word_addr;

  // In IDLE the lane logic checks the incoming request; afterwards it works
  // on the captured request so later core-side changes are ignored.
  always_comb begin
    if (r_state == ST_IDLE) begin
      w_lane = i_addr[1:0];
      w_f3   = i_funct3;
    end else begin
      w_lane = r_addr_lo;
      w_f3   = r_funct3;
    end
  end

  lsu_align u_align (
    .i_word     (i_mem_rdata),
    .i_addr_lo  (w_lane),
    .i_funct3   (w_f3),
    .i_wdata    (r_wdata),
    .o_load     (w_load),
    .o_merged   (w_merged),
    .o_misalign (w_misalign)
  );

  assign w_accept    = i_req_valid && r_req_ready;
  assign w_err       = (i_req_ld == i_req_sw) || !f3_legal(i_funct3, i_req_sw) || w_misalign;
  assign w_word_addr = {i_addr[ADDR_W-1:2], 2'b00};

  // Request FSM with all outputs registered; reset aborts any access at once.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_addr_lo    <= 2'd0;
      r_funct3     <= 3'd0;
      r_wdata      <= '0;
      r_req_ready  <= 1'b1;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
      r_mem_ld     <= 1'b0;
      r_mem_sw     <= 1'b0;
      r_resp_valid <= 1'b0;
      r_rdata      <= '0;
      r_err        <= 1'b0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr_lo   <= i_addr[1:0];
            r_funct3    <= i_funct3;
            r_wdata     <= i_wdata;
            if (w_err) begin
              r_state      <= ST_RESP;
              r_resp_valid <= 1'b1;
              r_err        <= 1'b1;
              r_rdata      <= '0;
            end else if (i_req_ld) begin
              r_state    <= ST_LOAD;
              r_mem_ld   <= 1'b1;
              r_mem_addr <= w_word_addr;
            end else if (i_funct3 == F3_W) begin
              r_state     <= ST_STORE;
              r_mem_sw    <= 1'b1;
              r_mem_addr  <= w_word_addr;
              r_mem_wdata <= i_wdata;
            end else begin
              r_state    <= ST_MERGE;
              r_mem_ld   <= 1'b1;
              r_mem_addr <= w_word_addr;
            end
          end
        end
        ST_LOAD: begin
          r_state      <= ST_RESP;
          r_mem_ld     <= 1'b0;
          r_mem_addr   <= '0;
          r_rdata      <= w_load;
          r_resp_valid <= 1'b1;
        end
        ST_MERGE: begin
          r_state     <= ST_STORE;
          r_mem_ld    <= 1'b0;
          r_mem_sw    <= 1'b1;
          r_mem_wdata <= w_merged;
        end
        ST_STORE: begin
          r_state      <= ST_RESP;
          r_mem_sw     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_rdata      <= '0;
          r_resp_valid <= 1'b1;
        end
        ST_RESP: begin
          r_state      <= ST_IDLE;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
          r_rdata      <= '0;
          r_req_ready  <= 1'b1;
        end
        default: begin
          r_state      <= ST_IDLE;
          r_mem_ld     <= 1'b0;
          r_mem_sw     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_resp_valid <= 1'b0;
          r_err        <= 1'b0;
          r_rdata      <= '0;
          r_req_ready  <= 1'b1;
        end
      endcase
    end
  end

  assign o_req_ready  = r_req_ready;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_mem_ld     = r_mem_ld;
  assign o_mem_sw     = r_mem_sw;
  assign o_resp_valid = r_resp_valid;
  assign o_rdata      = r_rdata;
  assign o_err        = r_err;

endmodule

// File: tb/tb_lsu_ctrl.sv
// Self-checking bench for lsu_ctrl with a behavioural word RAM and a
// scoreboard of expected responses.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_req_valid, i_req_ld, i_req_sw;
  logic [2:0]  i_funct3;
  logic [11:0] i_addr;
  logic [31:0] i_wdata;
  logic        o_req_ready, o_mem_ld, o_mem_sw, o_resp_valid, o_err;
  logic [11:0] o_mem_addr;
  logic [31:0] o_mem_wdata, i_mem_rdata, o_rdata;

  logic [31:0] ram [0:1023];

  int n_chk  = 0;
  int n_pass = 0;

  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          nld;
    int          nsw;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk          (clk),
    .reset        (reset),
    .i_req_valid  (i_req_valid),
    .o_req_ready  (o_req_ready),
    .i_req_ld     (i_req_ld),
    .i_req_sw     (i_req_sw),
    .i_funct3     (i_funct3),
    .i_addr       (i_addr),
    .i_wdata      (i_wdata),
    .o_mem_addr   (o_mem_addr),
    .o_mem_wdata  (o_mem_wdata),
    .o_mem_ld     (o_mem_ld),
    .o_mem_sw     (o_mem_sw),
    .i_mem_rdata  (i_mem_rdata),
    .o_resp_valid (o_resp_valid),
    .o_rdata      (o_rdata),
    .o_err        (o_err)
  );

  // Word RAM: combinational read, write on the clock edge.
  assign i_mem_rdata = ram[o_mem_addr[11:2]];
  always @(posedge clk) begin
    if (o_mem_sw) ram[o_mem_addr[11:2]] <= o_mem_wdata;
  end

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
  endtask

  // Drive one request, push its expectation, then watch the DUT until the
  // response pops the scoreboard.
  task automatic issue(input string tag, input logic ld, input logic sw, input logic [2:0] f3,
                       input logic [11:0] addr, input logic [31:0] wd, input logic [31:0] exp_rd,
                       input logic exp_err, input int lat, input int nld, input int nsw);
    exp_t e;
    exp_t got;
    int   cld = 0, csw = 0, cboth = 0, crdy = 0, cbad = 0;
    bit   done = 1'b0;
    @(negedge clk);
    check_val({tag, "/ready"}, {31'd0, o_req_ready}, 32'd1);
    i_req_valid = 1'b1; i_req_ld = ld; i_req_sw = sw; i_funct3 = f3;
    i_addr = addr; i_wdata = wd;
    e.rdata = exp_rd; e.err = exp_err; e.lat = lat; e.nld = nld; e.nsw = nsw;
    sb.push_back(e);
    @(posedge clk);
    #1;
    i_req_valid = 1'b0; i_req_ld = 1'b0; i_req_sw = 1'b0; i_funct3 = 3'b111;
    i_addr = ~addr; i_wdata = ~wd;
    for (int k = 1; k <= 6 && !done; k++) begin
      @(negedge clk);
      if (o_req_ready) crdy++;
      if (o_resp_valid) begin
        done = 1'b1;
        got = sb.pop_front();
        check_val({tag, "/rdata"}, o_rdata, got.rdata);
        check_val({tag, "/err"}, {31'd0, o_err}, {31'd0, got.err});
        check_val({tag, "/latency"}, 32'(k), 32'(got.lat));
        check_val({tag, "/ld_cycles"}, 32'(cld), 32'(got.nld));
        check_val({tag, "/sw_cycles"}, 32'(csw), 32'(got.nsw));
      end else begin
        if (o_mem_ld) cld++;
        if (o_mem_sw) csw++;
        if (o_mem_ld && o_mem_sw) cboth++;
        if ((o_mem_ld || o_mem_sw) && (o_mem_addr != {addr[11:2], 2'b00})) cbad++;
      end
    end
    check_val({tag, "/resp_seen"}, {31'd0, done}, 32'd1);
    if (!done && sb.size() > 0) sb.delete(0);
    check_val({tag, "/ld_and_sw"}, 32'(cboth), 32'd0);
    check_val({tag, "/busy_ready"}, 32'(crdy), 32'd0);
    check_val({tag, "/mem_addr"}, 32'(cbad), 32'd0);
  endtask

  // Hard time limit so the run always ends.
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nresp;
    reset = 1'b1;
    i_req_valid = 1'b0; i_req_ld = 1'b0; i_req_sw = 1'b0;
    i_funct3 = 3'd0; i_addr = 12'd0; i_wdata = 32'd0;
    for (int i = 0; i < 1024; i++) ram[i] = 32'd0;
    ram[4]    = 32'h12345678;
    ram[8]    = 32'h8899AABB;
    ram[17]   = 32'h11223344;
    ram[1023] = 32'hAAAAAAAA;

    repeat (2) @(negedge clk);
    check_val("rst/ready", {31'd0, o_req_ready}, 32'd1);
    check_val("rst/resp", {31'd0, o_resp_valid}, 32'd0);
    check_val("rst/ld", {31'd0, o_mem_ld}, 32'd0);
    check_val("rst/sw", {31'd0, o_mem_sw}, 32'd0);
    check_val("rst/addr", {20'd0, o_mem_addr}, 32'd0);
    check_val("rst/wdata", o_mem_wdata, 32'd0);
    check_val("rst/rdata", o_rdata, 32'd0);
    check_val("rst/err", {31'd0, o_err}, 32'd0);
    reset = 1'b0;

    // Abort an SW to 0x010 with reset while the write strobe is high.
    @(negedge clk);
    i_req_valid = 1'b1; i_req_ld = 1'b0; i_req_sw = 1'b1;
    i_funct3 = 3'b010; i_addr = 12'h010; i_wdata = 32'hCAFEF00D;
    @(posedge clk);
    #1;
    i_req_valid = 1'b0; i_req_sw = 1'b0;
    @(negedge clk);
    check_val("abort/sw_active", {31'd0, o_mem_sw}, 32'd1);
    #1 reset = 1'b1;
    #1 check_val("abort/sw_drop", {31'd0, o_mem_sw}, 32'd0);
    @(negedge clk);
    reset = 1'b0;
    check_val("abort/ram", ram[4], 32'h12345678);
    check_val("abort/ready", {31'd0, o_req_ready}, 32'd1);
    nresp = 0;
    repeat (4) begin
      @(negedge clk);
      if (o_resp_valid) nresp++;
    end
    check_val("abort/no_resp", 32'(nresp), 32'd0);

    // Sub-word loads from 0x8899AABB.
    issue("lb_021",  1'b1, 1'b0, 3'b000, 12'h021, 32'd0, 32'hFFFFFFAA, 1'b0, 2, 1, 0);
    issue("lbu_023", 1'b1, 1'b0, 3'b100, 12'h023, 32'd0, 32'h00000088, 1'b0, 2, 1, 0);
    issue("lh_022",  1'b1, 1'b0, 3'b001, 12'h022, 32'd0, 32'hFFFF8899, 1'b0, 2, 1, 0);
    issue("lhu_020", 1'b1, 1'b0, 3'b101, 12'h020, 32'd0, 32'h0000AABB, 1'b0, 2, 1, 0);

    // Word store then load back.
    issue("sw_040",  1'b0, 1'b1, 3'b010, 12'h040, 32'hDEADBEEF, 32'd0, 1'b0, 2, 0, 1);
    check_val("sw_040/ram", ram[16], 32'hDEADBEEF);
    issue("lw_040",  1'b1, 1'b0, 3'b010, 12'h040, 32'd0, 32'hDEADBEEF, 1'b0, 2, 1, 0);

    // Read-modify-write stores, including the top word.
    issue("sb_046",  1'b0, 1'b1, 3'b000, 12'h046, 32'h000000AB, 32'd0, 1'b0, 3, 1, 1);
    check_val("sb_046/ram", ram[17], 32'h11AB3344);
    issue("sh_ffe",  1'b0, 1'b1, 3'b001, 12'hFFE, 32'h1234CDEF, 32'd0, 1'b0, 3, 1, 1);
    check_val("sh_ffe/ram", ram[1023], 32'hCDEFAAAA);
    issue("lw_ffc",  1'b1, 1'b0, 3'b010, 12'hFFC, 32'd0, 32'hCDEFAAAA, 1'b0, 2, 1, 0);
    issue("lhu_ffe", 1'b1, 1'b0, 3'b101, 12'hFFE, 32'd0, 32'h0000CDEF, 1'b0, 2, 1, 0);

    // Error requests: no memory strobes, immediate response.
    issue("err_lw_053",  1'b1, 1'b0, 3'b010, 12'h053, 32'd0, 32'd0, 1'b1, 1, 0, 0);
    issue("err_sh_061",  1'b0, 1'b1, 3'b001, 12'h061, 32'h5555, 32'd0, 1'b1, 1, 0, 0);
    issue("err_both",    1'b1, 1'b1, 3'b010, 12'h040, 32'd0, 32'd0, 1'b1, 1, 0, 0);
    issue("err_neither", 1'b0, 1'b0, 3'b010, 12'h040, 32'd0, 32'd0, 1'b1, 1, 0, 0);
    issue("err_ld_f3",   1'b1, 1'b0, 3'b011, 12'h020, 32'd0, 32'd0, 1'b1, 1, 0, 0);
    issue("err_st_bu",   1'b0, 1'b1, 3'b100, 12'h020, 32'h77, 32'd0, 1'b1, 1, 0, 0);
    check_val("err_st_bu/ram", ram[8], 32'h8899AABB);

    check_val("sb/empty", 32'(sb.size()), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
